// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the Gray-code conversion arbiter.
// Holds the controller state encoding and the direction codes used by
// both the arbiter and the conversion engine.
package gray_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_B2G = 1'b0;
  localparam logic DIR_G2B = 1'b1;

endpackage

// File: rtl/gray_conv_engine.sv
// Conversion datapath shared by both requesters.
// Binary-to-Gray finishes in a single CONV cycle; Gray-to-binary walks
// one bit per cycle from the MSB down using a bit index counter.
// The Gray-to-binary path exists only when GRAY_CONV_G2B_EN is defined;
// otherwise a Gray-to-binary request passes the operand through and
// raises o_err.
module gray_conv_engine
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_conv,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_result,
  output logic             o_last,
  output logic             o_err
);

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_b2g;

  assign w_b2g    = i_operand ^ (i_operand >> 1);
  assign o_result = r_result;

`ifdef GRAY_CONV_G2B_EN
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDXW-1:0] r_idx;
  logic            w_upper;
  logic            w_g2b_bit;

  // Previously decoded (more significant) binary bit feeding the current step
  always_comb begin
    w_upper = 1'b0;
    if (r_idx != IDXW'(WIDTH - 1)) begin
      w_upper = r_result[r_idx + 1'b1];
    end
    w_g2b_bit = w_upper ^ i_operand[r_idx];
  end

  // Bit index walks from the MSB down to bit 0 while a G2B conversion runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_idx <= IDXW'(WIDTH - 1);
    end else if (i_conv && (i_dir == DIR_G2B) && (r_idx != '0)) begin
      r_idx <= r_idx - 1'b1;
    end
  end
`endif

  // Result register: cleared on each new operation, written during CONV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (i_load) begin
      r_result <= '0;
    end else if (i_conv) begin
      if (i_dir == DIR_B2G) begin
        r_result <= w_b2g;
      end else begin
`ifdef GRAY_CONV_G2B_EN
        r_result[r_idx] <= w_g2b_bit;
`else
        r_result <= i_operand;
`endif
      end
    end
  end

  // Flags the final CONV cycle and whether the request is unsupported
  always_comb begin
    o_last = 1'b1;
    o_err  = 1'b0;
`ifdef GRAY_CONV_G2B_EN
    if (i_dir == DIR_G2B) begin
      o_last = (r_idx == '0);
    end
`else
    o_err = (i_dir == DIR_G2B);
`endif
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end for the shared Gray-code engine.
// FSM IDLE -> CONV -> DONE; a single result is held in DONE until taken.
// Optional feature macro: GRAY_CONV_G2B_EN (enables Gray-to-binary).
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_dir,
  input  logic [2*WIDTH-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               rsp_err
);

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_id;
  logic             r_dir;
  logic [WIDTH-1:0] r_operand;
  logic             w_any;
  logic             w_grant;
  logic             w_hs;
  logic             w_last;
  logic             w_err;
  logic [WIDTH-1:0] w_result;

  // Round-robin pick: a tie goes to whoever was not served last
  always_comb begin
    w_any = |req_valid;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req_valid[1];
    end
    w_hs = (r_state == IDLE) && w_any;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = CONV;
      CONV:    if (w_last) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the winning request and remember who was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_dir        <= DIR_B2G;
      r_operand    <= '0;
    end else if (w_hs) begin
      r_last_grant <= w_grant;
      r_id         <= w_grant;
      r_dir        <= req_dir[w_grant];
      r_operand    <= w_grant ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    end
  end

  gray_conv_engine #(
    .WIDTH(WIDTH)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_hs),
    .i_conv   (r_state == CONV),
    .i_dir    (r_dir),
    .i_operand(r_operand),
    .o_result (w_result),
    .o_last   (w_last),
    .o_err    (w_err)
  );

  // Outputs: ready only while idle and out of reset, response only in DONE
  always_comb begin
    req_ready = 2'b00;
    if ((r_state == IDLE) && w_any && rst_n) begin
      req_ready[w_grant] = 1'b1;
    end
    rsp_valid = (r_state == DONE);
    rsp_data  = (r_state == DONE) ? w_result : '0;
    rsp_id    = (r_state == DONE) && r_id;
    rsp_err   = (r_state == DONE) && w_err;
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter (WIDTH = 4).
// Honours GRAY_CONV_G2B_EN so the model matches whichever build is compiled.
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_dir;
  logic [2*W-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_id;
  logic           rsp_err;

  gray_conv_arbiter #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dir  (req_dir),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .rsp_err  (rsp_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         id;
    logic         err;
    int           lat;
    int           hsCycle;
    bit           seen;
  } exp_t;

  exp_t sbQ[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cycle      = 0;
  int   lastGrant  = 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout expected completion (cycle %0d)", name, cycle);
  endtask

  // Reference conversions from the definition of the reflected Gray code
  function automatic logic [W-1:0] binToGray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] grayToBin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic exp_t modelOp(input int id, input logic dir, input logic [W-1:0] d);
    exp_t e;
    e.id = id[0];
    e.seen = 0;
    e.hsCycle = 0;
    if (dir == 1'b0) begin
      e.data = binToGray(d);
      e.err  = 1'b0;
      e.lat  = 2;
    end else begin
`ifdef GRAY_CONV_G2B_EN
      e.data = grayToBin(d);
      e.err  = 1'b0;
      e.lat  = W + 1;
`else
      e.data = d;
      e.err  = 1'b1;
      e.lat  = 2;
`endif
    end
    return e;
  endfunction

  // Monitor: predicts grants, pushes expectations, pops on each response
  always @(negedge clk) begin
    logic [1:0] expReady;
    int         winner;
    exp_t       e;
    cycle++;
    if (!rst_n) begin
      sbQ.delete();
      lastGrant = 1;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      expReady = 2'b00;
      winner   = 0;
      if (sbQ.size() == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) winner = (lastGrant == 1) ? 0 : 1;
        else winner = req_valid[1] ? 1 : 0;
        expReady[winner] = 1'b1;
      end
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      if (expReady != 2'b00) begin
        e = modelOp(winner, req_dir[winner], req_data[winner*W +: W]);
        e.hsCycle = cycle;
        sbQ.push_back(e);
        lastGrant = winner;
      end
      if (rsp_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          if (!sbQ[0].seen) begin
            checkOutput("latency", 32'(cycle - sbQ[0].hsCycle), 32'(sbQ[0].lat));
            sbQ[0].seen = 1;
          end
          checkOutput("rsp_data", 32'(rsp_data), 32'(sbQ[0].data));
          checkOutput("rsp_id", 32'(rsp_id), 32'(sbQ[0].id));
          checkOutput("rsp_err", 32'(rsp_err), 32'(sbQ[0].err));
          if (rsp_ready) void'(sbQ.pop_front());
        end
      end else if (sbQ.size() != 0 && (cycle - sbQ[0].hsCycle) > 40) begin
        reportTimeout("response");
        void'(sbQ.pop_front());
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until it is accepted
  task automatic applyStimulus(input int id, input logic dir, input logic [W-1:0] d);
    bit done;
    done = 0;
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    req_dir[id] = dir;
    req_data[id*W +: W] = d;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) done = 1;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    if (!done) reportTimeout("handshake");
  endtask

  task automatic waitRspValid();
    bit seen;
    seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    if (!seen) reportTimeout("wait_rsp_valid");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed scenarios, then a randomized soak
  initial begin
    int hsCount;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_dir   = 2'b00;
    req_data  = '0;
    rsp_ready = 1'b1;
    #1;
    checkAllZero("por");
    waitCycles(3);
    rst_n = 1'b1;

    $display("[TB] single B2G and G2B requests");
    applyStimulus(0, 1'b0, 4'b0111);
    waitCycles(5);
    applyStimulus(1, 1'b1, 4'b1000);
    waitCycles(10);

    $display("[TB] tie after reset and alternating grants");
    pulseReset();
    req_dir   = 2'b00;
    req_data  = {4'd2, 4'd15};
    req_valid = 2'b11;
    hsCount   = 0;
    for (int t = 0; t < 100 && hsCount < 6; t++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) hsCount++;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    if (hsCount < 6) reportTimeout("alternation");
    waitCycles(5);

    $display("[TB] stalled response");
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 4'b0110);
    waitRspValid();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitCycles(3);

    $display("[TB] reset during conversion");
    applyStimulus(1, 1'b1, 4'b1011);
    #2;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    checkAllZero("reset_conv");
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    waitCycles(12);

    $display("[TB] reset while holding a response");
    rsp_ready = 1'b0;
    applyStimulus(1, 1'b0, 4'b1110);
    waitRspValid();
    #2;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    checkAllZero("reset_done");
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    waitCycles(10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      req_valid = 2'($urandom);
      req_dir   = 2'($urandom);
      req_data  = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    waitCycles(30);
    if (sbQ.size() != 0) reportTimeout("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning code word width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready, output, 2, per-requester accept.
REQ-006 SHALL have port req_dir, input, 2, per-requester direction (0 = binary-to-Gray, 1 = Gray-to-binary).
REQ-007 SHALL have port req_data, input, 2*WIDTH, per-requester operand (requester i at bits [i*WIDTH +: WIDTH]).
REQ-008 SHALL have port rsp_valid, output, 1, result valid.
REQ-009 SHALL have port rsp_ready, input, 1, downstream accept.
REQ-010 SHALL have port rsp_data, output, WIDTH, conversion result.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-012 SHALL have port rsp_err, output, 1, request unsupported in this build.

Function
REQ-013 SHALL share one conversion engine between two requesters under an FSM with states IDLE, CONV, DONE.
REQ-014 SHALL, in IDLE, grant round-robin: one valid requester wins alone; if both are valid, the requester not granted last wins; requester 0 wins the first tie after reset.
REQ-015 SHALL drive req_ready[i] = 1 combinationally only in IDLE with i granted; req_ready SHALL be 0 in CONV and DONE.
REQ-016 SHALL, on a handshake (valid & ready), register operand, direction and id, then move to CONV on the next edge.
REQ-017 SHALL compute binary-to-Gray as g[W-1] = b[W-1], g[i] = b[i+1] ^ b[i], in exactly one CONV cycle.
REQ-018 SHALL compute Gray-to-binary iteratively, MSB first, one bit per CONV cycle: b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i], taking exactly WIDTH CONV cycles.
REQ-019 SHALL enter DONE after the last CONV cycle and hold rsp_valid = 1 with rsp_data, rsp_id and rsp_err stable until rsp_ready = 1.
REQ-020 SHALL leave DONE for IDLE on the rsp_valid & rsp_ready edge; the next grant SHALL occur no earlier than the following IDLE cycle.
REQ-021 SHALL have response latency, handshake edge to first rsp_valid cycle, of 2 cycles for binary-to-Gray and WIDTH+1 cycles for Gray-to-binary.
REQ-022 SHALL ignore changes to req_* while in CONV or DONE.
REQ-023 SHALL treat all values as unsigned; 0 and 2^WIDTH-1 SHALL need no special handling.

Reset
REQ-024 SHALL, while rst_n = 0, force state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, req_ready 0, and the last-grant pointer to 1 (so requester 0 wins next).
REQ-025 SHALL, if reset occurs mid-conversion or in DONE, discard the operation with no response after reset release.

Configuration
REQ-026 SHALL compile the Gray-to-binary path only if macro GRAY_CONV_G2B_EN is defined.
REQ-027 SHALL, with GRAY_CONV_G2B_EN defined, behave per REQ-018 and drive rsp_err = 0 always.
REQ-028 SHALL, without GRAY_CONV_G2B_EN, complete a dir = 1 request after one CONV cycle with rsp_data = operand unchanged and rsp_err = 1; dir = 0 SHALL be unaffected.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/CONV/DONE) and the direction constants DIR_B2G = 0, DIR_G2B = 1 in shared package gray_conv_pkg.
REQ-030 SHALL implement the conversion datapath (one-shot B2G plus bit-serial G2B with bit index counter) as sub-module gray_conv_engine; the arbiter/FSM SHALL be in gray_conv_arbiter.

Verification (WIDTH = 4, GRAY_CONV_G2B_EN defined unless noted)
REQ-031 SHALL check: req 0 B2G 4'b0111, rsp_ready = 1 -> rsp_valid 2 cycles after handshake, rsp_data 4'b0100, rsp_id 0.
REQ-032 SHALL check: req 1 G2B 4'b1000 -> rsp_valid 5 cycles after handshake, rsp_data 4'b1111, rsp_id 1, rsp_err 0.
REQ-033 SHALL check: both valid after reset (B2G 4'd15 and 4'd2) -> requester 0 first (4'b1000), then requester 1 (4'b0011); with both kept valid, grants alternate 0,1,0,1.
REQ-034 SHALL check: rsp_ready held 0 for 3 cycles in DONE -> rsp_valid/rsp_data stable, req_ready 0 throughout.
REQ-035 SHALL check: rst_n pulsed low during G2B CONV -> all outputs 0 immediately; no response after release.
REQ-036 SHALL check, without GRAY_CONV_G2B_EN: G2B 4'b1010 -> rsp_data 4'b1010, rsp_err 1, 2 cycles after handshake.
